// File: rtl/priority_encoder_pkg.sv
// Shared widths and idle code for the 8-to-3 active-low priority encoder.
package priority_encoder_pkg;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CODE_W = 3;
  localparam logic [CODE_W-1:0] IDLE_CODE_N = 3'b111;
endpackage

// File: rtl/priority_encoder8_3_core.sv
// Combinational 8-to-3 priority encoder; active-low inputs and outputs, bit 7 wins.
module priority_encoder8_3_core
  import priority_encoder_pkg::*;
(
  input  logic [DATA_W-1:0] i_data_n,
  input  logic              i_enable_n,
  output logic [CODE_W-1:0] o_data_n,
  output logic              o_gs_n,
  output logic              o_enable_n
);

  logic [CODE_W-1:0] code;
  logic              any_req;

  // Ascending scan: the last active bit seen is the highest-priority one.
  always_comb begin
    code    = '0;
    any_req = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (!i_data_n[i]) begin
        code    = CODE_W'(i);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    o_data_n   = IDLE_CODE_N;
    o_gs_n     = 1'b1;
    o_enable_n = 1'b1;
    if (!i_enable_n) begin
      if (any_req) begin
        o_data_n = ~code;
        o_gs_n   = 1'b0;
      end else begin
        o_enable_n = 1'b0;
      end
    end
  end

endmodule

// File: rtl/priority_encoder8_3.sv
// Priority encoder top: combinational core plus an optional output register stage.
module priority_encoder8_3
  import priority_encoder_pkg::*;
#(
  parameter bit OUT_REG = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data_n,
  input  logic              i_enable_n,
  output logic [CODE_W-1:0] o_data_n,
  output logic              o_gs_n,
  output logic              o_enable_n
);

  logic [CODE_W-1:0] data_d;
  logic              gs_d;
  logic              enable_d;

  priority_encoder8_3_core u_core (
    .i_data_n   (i_data_n),
    .i_enable_n (i_enable_n),
    .o_data_n   (data_d),
    .o_gs_n     (gs_d),
    .o_enable_n (enable_d)
  );

  if (OUT_REG) begin : g_reg
    logic [CODE_W-1:0] data_q;
    logic              gs_q;
    logic              enable_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        data_q   <= IDLE_CODE_N;
        gs_q     <= 1'b1;
        enable_q <= 1'b1;
      end else begin
        data_q   <= data_d;
        gs_q     <= gs_d;
        enable_q <= enable_d;
      end
    end

    assign o_data_n   = data_q;
    assign o_gs_n     = gs_q;
    assign o_enable_n = enable_q;
  end else begin : g_comb
    // Clock and reset have no function without the register stage.
    logic unused_clk_rst;
    assign unused_clk_rst = i_clk ^ i_rst;

    assign o_data_n   = data_d;
    assign o_gs_n     = gs_d;
    assign o_enable_n = enable_d;
  end

endmodule

// File: tb/tb_priority_encoder8_3.sv
// Self-checking bench: registered and combinational instances checked against a scoreboard.
module tb_priority_encoder8_3;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_data_n;
  logic       i_enable_n;

  logic [2:0] r_data_n, c_data_n;
  logic       r_gs_n, c_gs_n;
  logic       r_en_n, c_en_n;

  int total = 0;
  int bad   = 0;

  // Expected {o_data_n, o_gs_n, o_enable_n} for the registered instance.
  logic [4:0] sb[$];

  always #5 i_clk = ~i_clk;

  priority_encoder8_3 #(.OUT_REG(1'b1)) dut_reg (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_data_n   (i_data_n),
    .i_enable_n (i_enable_n),
    .o_data_n   (r_data_n),
    .o_gs_n     (r_gs_n),
    .o_enable_n (r_en_n)
  );

  priority_encoder8_3 #(.OUT_REG(1'b0)) dut_comb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_data_n   (i_data_n),
    .i_enable_n (i_enable_n),
    .o_data_n   (c_data_n),
    .o_gs_n     (c_gs_n),
    .o_enable_n (c_en_n)
  );

  function automatic logic [4:0] model(input logic en_n, input logic [7:0] d);
    if (en_n) return 5'b111_1_1;
    for (int i = 7; i >= 0; i--) begin
      if (d[i] == 1'b0) return {~3'(i), 1'b0, 1'b1};
    end
    return 5'b111_1_0;
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic en_n, input logic [7:0] d, input logic [4:0] exp,
                       input string tag);
    @(negedge i_clk);
    i_enable_n = en_n;
    i_data_n   = d;
    sb.push_back(exp);
    #1;
    check({tag, "_comb"}, {c_data_n, c_gs_n, c_en_n}, exp);
    @(posedge i_clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 5'b00000, 5'b11111);
    end else begin
      check({tag, "_reg"}, {r_data_n, r_gs_n, r_en_n}, sb.pop_front());
    end
  endtask

  logic [7:0] sweep_in [8];
  logic [2:0] sweep_out[8];

  initial begin
    sweep_in  = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    sweep_out = '{3'b111, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000};

    i_rst      = 1'b1;
    i_enable_n = 1'b0;
    i_data_n   = 8'h00;
    #1;
    check("reset_state", {r_data_n, r_gs_n, r_en_n}, 5'b111_1_1);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Disabled: requests ignored.
    apply(1'b1, 8'hFF, 5'b111_1_1, "dis_ff");
    apply(1'b1, 8'h00, 5'b111_1_1, "dis_00");

    // Enabled, no request, then the encoding sweep.
    apply(1'b0, 8'hFF, 5'b111_1_0, "en_noreq");
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, sweep_in[i], {sweep_out[i], 1'b0, 1'b1}, $sformatf("sweep%0d", i));
    end

    apply(1'b0, 8'b1110_1010, 5'b011_0_1, "priority");

    // Asynchronous reset mid-stream, then resume on the first edge after release.
    apply(1'b0, 8'h00, 5'b000_0_1, "pre_rst");
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check("rst_async", {r_data_n, r_gs_n, r_en_n}, 5'b111_1_1);
    @(posedge i_clk);
    #1;
    check("rst_hold", {r_data_n, r_gs_n, r_en_n}, 5'b111_1_1);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("rst_release", {r_data_n, r_gs_n, r_en_n}, 5'b111_1_1);
    @(posedge i_clk);
    #1;
    check("rst_resume", {r_data_n, r_gs_n, r_en_n}, 5'b000_0_1);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      apply(v[8], v[7:0], model(v[8], v[7:0]), $sformatf("exh_%03h", v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/priority_encoder8_3.md
PRIORITY_ENCODER8_3 -- requirements
Module: priority_encoder8_3

Interface
REQ-001 The block SHALL have one parameter: OUT_REG, default 1, where 1 means outputs are registered and 0 means outputs are combinational.
REQ-002 The block SHALL have port i_clk, input, 1 bit: single clock; all registers sample on its rising edge.
REQ-003 The block SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port i_data_n, input, 8 bits: request lines, active-low; bit 7 is highest priority.
REQ-005 The block SHALL have port i_enable_n, input, 1 bit: enable input, active-low.
REQ-006 The block SHALL have port o_data_n, output, 3 bits: encoded index of the highest-priority active request, inverted (active-low code).
REQ-007 The block SHALL have port o_gs_n, output, 1 bit: group select, active-low; low when enabled and at least one request is active.
REQ-008 The block SHALL have port o_enable_n, output, 1 bit: enable output for cascading, active-low; low when enabled and no request is active.

Function
REQ-009 Disabled (i_enable_n=1): the block SHALL drive o_data_n=3'b111, o_gs_n=1, o_enable_n=1, regardless of i_data_n.
REQ-010 Enabled with no request (i_enable_n=0, i_data_n=8'hFF): the block SHALL drive o_data_n=3'b111, o_gs_n=1, o_enable_n=0.
REQ-011 Enabled with any request: let n be the highest index with i_data_n[n]=0; the block SHALL drive o_data_n=~n (3 bits), o_gs_n=0, o_enable_n=1.
REQ-012 Lower-index requests SHALL be ignored whenever a higher-index request is active (e.g. 8'b0000_0000 encodes as n=7).
REQ-013 Encoding examples: 8'hFE gives o_data_n=111; 8'hFC gives 110; 8'hF8 gives 101; 8'hF0 gives 100; 8'hE0 gives 011; 8'hC0 gives 010; 8'h80 gives 001; 8'h00 gives 000.
REQ-014 OUT_REG=1: outputs SHALL reflect inputs sampled at the previous rising i_clk edge (latency exactly 1 cycle), and all three outputs SHALL update on the same edge.
REQ-015 OUT_REG=0: outputs SHALL be a pure combinational function of i_data_n and i_enable_n, with zero latency; i_clk and i_rst are then unused.
REQ-016 X or Z on any i_data_n bit or on i_enable_n is outside the contract; no output value is guaranteed for it.
REQ-017 The block SHALL have no internal state other than the output registers, and no handshake.

Reset
REQ-018 While i_rst=1, registered outputs SHALL immediately (asynchronously) take o_data_n=3'b111, o_gs_n=1, o_enable_n=1.
REQ-019 Reset deassertion SHALL be synchronised externally; on the first rising edge after i_rst falls, outputs SHALL load the encoding of the current inputs.
REQ-020 Reset asserted mid-operation SHALL override any pending update on that edge.

Structure
REQ-021 A shared package priority_encoder_pkg SHALL hold the constants IDLE_CODE_N=3'b111, the data width 8, and the code width 3.
REQ-022 The combinational encoder SHALL be a sub-module named priority_encoder8_3_core (i_data_n, i_enable_n to o_data_n, o_gs_n, o_enable_n), and the top SHALL add the optional output register stage.

Verification
REQ-023 i_rst=1 pulse mid-stream -> outputs are 111/1/1 asynchronously (before the next edge), and resume encoding the edge after release.
REQ-024 i_enable_n=1, i_data_n swept 8'hFF and 8'h00 -> o_data_n=111, o_gs_n=1, o_enable_n=1 one cycle later.
REQ-025 i_enable_n=0, i_data_n=8'hFF -> 111/1/0; then sweep 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00 -> o_data_n 111, 110, 101, 100, 011, 010, 001, 000, each with o_gs_n=0 and o_enable_n=1, each one cycle later.
REQ-026 Priority check: i_data_n=8'b1110_1010 (requests at 4, 2, 0) -> o_data_n=011 (n=4).
REQ-027 Exhaustive: all 512 combinations of (i_enable_n, i_data_n) are compared against a reference model for both OUT_REG=1 (1-cycle delay) and OUT_REG=0 (same-cycle).
